// File: rtl/ddr_app_responder.sv
// ddr_app_responder
//   Memory end of the DDR application command/data protocol. Accepts one
//   read or write command per cycle into an on-chip word array and returns
//   read data in accept order after a fixed latency. Throttles commands with
//   periodic refresh stalls and a read-credit limit.
//
// Ports
//   clk                      single clock
//   rst                      synchronous reset, active-low
//   in_addr                  command address (word index = addr[ADDR_SHIFT +: log2(MEM_DEPTH)])
//   in_data                  write data
//   in_wrt_enbl              1 = write command, 0 = read command
//   in_available             command valid
//   in_burst_done            write data valid, expected with every write
//   in_wdf_mask              byte mask, 1 = byte not written
//   in_receive_enbl          consumer pops the read-return head
//   mem_in_ready_to_receive  command accept enable
//   mem_in_data              read-return head word (registered)
//   mem_in_data_ready        read-return buffer non-empty
//   err_wr_no_data           sticky: write accepted without in_burst_done
module ddr_app_responder #(
  parameter int LEN_ADDR       = 32,
  parameter int LEN_DATA       = 512,
  parameter int MEM_DEPTH      = 1024,
  parameter int ADDR_SHIFT     = 3,
  parameter int READ_LATENCY   = 4,
  parameter int RET_DEPTH      = 16,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_ADDR-1:0]   in_addr,
  input  logic [LEN_DATA-1:0]   in_data,
  input  logic                  in_wrt_enbl,
  input  logic                  in_available,
  input  logic                  in_burst_done,
  input  logic [LEN_DATA/8-1:0] in_wdf_mask,
  input  logic                  in_receive_enbl,
  output logic                  mem_in_ready_to_receive,
  output logic [LEN_DATA-1:0]   mem_in_data,
  output logic                  mem_in_data_ready,
  output logic                  err_wr_no_data
);

  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int NB    = LEN_DATA / 8;
  localparam int RW    = $clog2(RET_DEPTH);
  localparam int OW    = RW + 1;
  localparam int PER_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int LEN_W = (REFRESH_LEN > 1) ? $clog2(REFRESH_LEN) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(REFRESH_LEN - 1);

  typedef enum logic {ST_RUN, ST_REFRESH} state_t;

  state_t                r_state, w_state_nxt;
  logic [PER_W-1:0]      r_per_cnt, w_per_nxt;
  logic [LEN_W-1:0]      r_len_cnt, w_len_nxt;

  logic [LEN_DATA-1:0]   r_mem [MEM_DEPTH];

  logic [LEN_DATA-1:0]   r_pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pipe_vld;

  logic [LEN_DATA-1:0]   r_fifo [RET_DEPTH];
  logic [RW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]         r_fcnt;
  logic [OW-1:0]         r_outst;
  logic [LEN_DATA-1:0]   r_head;
  logic                  r_err;

  logic [AW-1:0]         w_idx;
  logic                  w_accept, w_rd_acc, w_wr_acc;
  logic                  w_push, w_pop;
  logic [LEN_DATA-1:0]   w_push_data;
  logic [RW-1:0]         w_rd_nxt;
  logic                  w_unused_addr;

  assign w_idx         = in_addr[ADDR_SHIFT +: AW];
  assign w_unused_addr = ^in_addr;

  // Ready depends only on registered state (and the reset level), so an
  // initiator that waits on ready never forms a combinational loop with us.
  assign mem_in_ready_to_receive = (r_state == ST_RUN) && (r_outst < OW'(RET_DEPTH)) && rst;

  assign w_accept    = in_available & mem_in_ready_to_receive;
  assign w_rd_acc    = w_accept & ~in_wrt_enbl;
  assign w_wr_acc    = w_accept & in_wrt_enbl;
  assign w_push      = r_pipe_vld[READ_LATENCY-1];
  assign w_push_data = r_pipe_data[READ_LATENCY-1];
  assign w_pop       = mem_in_data_ready & in_receive_enbl;
  assign w_rd_nxt    = r_rd_ptr + RW'(1);

  assign mem_in_data       = r_head;
  assign mem_in_data_ready = (r_fcnt != '0);
  assign err_wr_no_data    = r_err;

  // ---- refresh FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_per_cnt <= '0;
      r_len_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_per_cnt <= w_per_nxt;
      r_len_cnt <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per_cnt;
    w_len_nxt   = r_len_cnt;
    case (r_state)
      ST_RUN: begin
        if (REFRESH_PERIOD != 0) begin
          if (r_per_cnt == PER_LAST) begin
            w_per_nxt   = '0;
            w_len_nxt   = '0;
            w_state_nxt = ST_REFRESH;
          end else begin
            w_per_nxt = r_per_cnt + PER_W'(1);
          end
        end
      end
      ST_REFRESH: begin
        if (r_len_cnt == LEN_LAST) begin
          w_len_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_len_nxt = r_len_cnt + LEN_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // ---- array write (byte-masked) at the accepting edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (!in_wdf_mask[b]) r_mem[w_idx][8*b +: 8] <= in_data[8*b +: 8];
      end
    end
  end

  // ---- read latency pipe: stage 0 samples the array at the accepting edge
  always_ff @(posedge clk) begin
    r_pipe_data[0] <= r_mem[w_idx];
    for (int i = 1; i < READ_LATENCY; i++) r_pipe_data[i] <= r_pipe_data[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  // ---- return FIFO; the outstanding-read credit bounds its occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      r_outst  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + RW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + OW'(1);
        2'b01:   r_fcnt <= r_fcnt - OW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      case ({w_rd_acc, w_pop})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_wr_acc && !in_burst_done) r_err <= 1'b1;
    end
  end

  // Head register tracks what the FIFO head will be after this edge: the
  // next stored entry on a pop, or the incoming word when the FIFO is (or
  // becomes) empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_fcnt > OW'(1))  r_head <= r_fifo[w_rd_nxt];
      else if (w_push)      r_head <= w_push_data;
    end else if ((r_fcnt == '0) && w_push) begin
      r_head <= w_push_data;
    end
  end

endmodule

// File: tb/tb_ddr_app_responder.sv
module tb_ddr_app_responder;

  localparam int LEN_ADDR = 32;
  localparam int LEN_DATA = 512;
  localparam int NB       = LEN_DATA / 8;
  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_SHIFT = 3;
  localparam int READ_LATENCY = 4;
  localparam int RET_DEPTH = 16;
  localparam int AW = $clog2(MEM_DEPTH);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [LEN_ADDR-1:0] in_addr = '0;
  logic [LEN_DATA-1:0] in_data = '0;
  logic                in_wrt_enbl = 1'b0;
  logic                in_available = 1'b0;
  logic                in_burst_done = 1'b0;
  logic [NB-1:0]       in_wdf_mask = '0;
  logic                in_receive_enbl = 1'b0;
  logic                mem_in_ready_to_receive;
  logic [LEN_DATA-1:0] mem_in_data;
  logic                mem_in_data_ready;
  logic                err_wr_no_data;

  ddr_app_responder #(
    .LEN_ADDR(LEN_ADDR), .LEN_DATA(LEN_DATA), .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SHIFT(ADDR_SHIFT), .READ_LATENCY(READ_LATENCY), .RET_DEPTH(RET_DEPTH),
    .REFRESH_PERIOD(32), .REFRESH_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .in_data(in_data),
    .in_wrt_enbl(in_wrt_enbl), .in_available(in_available),
    .in_burst_done(in_burst_done), .in_wdf_mask(in_wdf_mask),
    .in_receive_enbl(in_receive_enbl),
    .mem_in_ready_to_receive(mem_in_ready_to_receive),
    .mem_in_data(mem_in_data), .mem_in_data_ready(mem_in_data_ready),
    .err_wr_no_data(err_wr_no_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic [LEN_DATA-1:0] mdl [MEM_DEPTH];
  logic [LEN_DATA-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [LEN_DATA-1:0] got, input logic [LEN_DATA-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs already set: predicts what the coming
  // posedge does, then advances to the following negedge.
  task automatic step();
    logic [AW-1:0] idx;
    idx = in_addr[ADDR_SHIFT +: AW];
    if (in_available && mem_in_ready_to_receive) begin
      n_acc++;
      if (in_wrt_enbl) begin
        for (int b = 0; b < NB; b++)
          if (!in_wdf_mask[b]) mdl[idx][8*b +: 8] = in_data[8*b +: 8];
      end else begin
        exp_q.push_back(mdl[idx]);
      end
    end
    if (mem_in_data_ready && in_receive_enbl) begin
      n_pop++;
      if (exp_q.size() == 0) chk("pop_unexpected", LEN_DATA'(exp_q.size()), 1);
      else chk("rd_data", mem_in_data, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit wr, input int addr, input logic [LEN_DATA-1:0] data,
                      input logic [NB-1:0] mask, input bit bd);
    bit done;
    done = 1'b0;
    in_wrt_enbl   = wr;
    in_addr       = LEN_ADDR'(addr);
    in_data       = data;
    in_wdf_mask   = mask;
    in_burst_done = bd;
    in_available  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = mem_in_ready_to_receive;
      step();
    end
    in_available  = 1'b0;
    in_burst_done = 1'b0;
    chk("accepted", LEN_DATA'(done), 1);
  endtask

  task automatic drain(input string tag);
    in_receive_enbl = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    in_receive_enbl = 1'b0;
    chk({tag, "_qempty"}, LEN_DATA'(exp_q.size()), 0);
    repeat (READ_LATENCY + 2) step();
    chk({tag, "_nodup"}, LEN_DATA'(mem_in_data_ready), 0);
  endtask

  task automatic do_reset();
    in_available    = 1'b0;
    in_receive_enbl = 1'b0;
    in_burst_done   = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", LEN_DATA'(mem_in_ready_to_receive), 0);
    chk("rst_dready", LEN_DATA'(mem_in_data_ready), 0);
    chk("rst_err", LEN_DATA'(err_wr_no_data), 0);
    chk("rst_data", mem_in_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [NB-1:0] m;
    int a0, p0;
    bit exp_rdy;

    // basic write/read and latency; also seed words 0..15
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = (32'(i) * 32'h01010101) ^ 32'hDEADBEEF;
      send(1'b1, i * 8, {16{w}}, '0, 1'b1);
    end
    send(1'b1, 32'h08, {NB{8'hA5}}, '0, 1'b1);
    send(1'b0, 32'h08, '0, '0, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      chk("lat_dready", LEN_DATA'(mem_in_data_ready), LEN_DATA'(k == 4));
      if (k < 4) step();
    end
    chk("lat_data", mem_in_data, {NB{8'hA5}});
    in_receive_enbl = 1'b1;
    step();
    in_receive_enbl = 1'b0;
    chk("pop_clear", LEN_DATA'(mem_in_data_ready), 0);

    // byte mask
    do_reset();
    send(1'b1, 32'h10, {NB{8'hFF}}, '0, 1'b1);
    m = '1;
    m[0] = 1'b0;
    send(1'b1, 32'h10, '0, m, 1'b1);
    send(1'b0, 32'h10, '0, '0, 1'b0);
    drain("mask");

    // credit limit: 16 back-to-back reads without pops
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_rdy", LEN_DATA'(mem_in_ready_to_receive), 1);
      send(1'b0, i * 8, '0, '0, 1'b0);
    end
    chk("full_rdy", LEN_DATA'(mem_in_ready_to_receive), 0);
    in_wrt_enbl = 1'b0; in_addr = '0; in_available = 1'b1;
    step(); step();
    in_available = 1'b0;
    repeat (3) step();
    in_receive_enbl = 1'b1;
    step();
    in_receive_enbl = 1'b0;
    chk("pop_rdy", LEN_DATA'(mem_in_ready_to_receive), 1);
    drain("b2b");
    chk("b2b_pops", LEN_DATA'(n_pop - p0), 16);

    // refresh stalls with continuous reads and pops
    do_reset();
    a0 = n_acc;
    p0 = n_pop;
    in_receive_enbl = 1'b1;
    in_wrt_enbl = 1'b0;
    in_available = 1'b1;
    for (int c = 0; c < 90; c++) begin
      in_addr = LEN_ADDR'(((n_acc - a0) % 16) * 8);
      exp_rdy = !((c >= 32 && c <= 39) || (c >= 72 && c <= 79));
      chk("ref_rdy", LEN_DATA'(mem_in_ready_to_receive), LEN_DATA'(exp_rdy));
      step();
    end
    in_available = 1'b0;
    chk("ref_acc", LEN_DATA'(n_acc - a0), 74);
    drain("ref");
    chk("ref_pops", LEN_DATA'(n_pop - p0), LEN_DATA'(n_acc - a0));

    // sticky write-without-data error
    do_reset();
    send(1'b1, 32'h20, {NB{8'h11}}, '0, 1'b1);
    chk("err_clean", LEN_DATA'(err_wr_no_data), 0);
    send(1'b1, 32'h20, {NB{8'h3C}}, '0, 1'b0);
    chk("err_set", LEN_DATA'(err_wr_no_data), 1);
    repeat (3) step();
    chk("err_sticky", LEN_DATA'(err_wr_no_data), 1);
    send(1'b0, 32'h20, '0, '0, 1'b0);
    drain("err");
    do_reset();
    chk("err_cleared", LEN_DATA'(err_wr_no_data), 0);

    // reset with reads in flight
    send(1'b0, 32'h28, '0, '0, 1'b0);
    send(1'b0, 32'h30, '0, '0, 1'b0);
    send(1'b0, 32'h38, '0, '0, 1'b0);
    step();
    do_reset();
    chk("post_rst_dready", LEN_DATA'(mem_in_data_ready), 0);
    repeat (READ_LATENCY + 2) step();
    chk("post_rst_stale", LEN_DATA'(mem_in_data_ready), 0);
    send(1'b0, 32'h30, '0, '0, 1'b0);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Synthesizable DDR application-interface responder: the memory end of the command/data protocol driven by the scheduler-to-DDR issue bridge.
- Accepts read/write commands with write data, stores into an on-chip array, and returns read data in order after a fixed latency.
- Asserts the bridge's "ready to receive" and "data ready" handshakes, with periodic refresh stalls and credit backpressure.
- Serves as the memory stand-in for board-less simulation and on-chip bring-up of the MTTKRP datapath.

Parameters:
LEN_ADDR, 32, command address width
LEN_DATA, 512, data word width (multiple of 8)
MEM_DEPTH, 1024, words in backing array (power of 2)
ADDR_SHIFT, 3, low address bits dropped to form the word index (burst-8 column addressing)
READ_LATENCY, 4, cycles from read accept to data visible (>=1)
RET_DEPTH, 16, max outstanding reads, i.e. return-buffer entries (power of 2)
REFRESH_PERIOD, 256, cycles between refresh stalls (0 disables refresh)
REFRESH_LEN, 8, cycles ready is held low per refresh (>=1)

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-low
in_addr  in  LEN_ADDR  command address
in_data  in  LEN_DATA  write data
in_wrt_enbl  in  1  1 = write command, 0 = read command
in_available  in  1  command valid
in_burst_done  in  1  write data valid; must accompany every write command
in_wdf_mask  in  LEN_DATA/8  byte mask; 1 = byte NOT written
in_receive_enbl  in  1  consumer pops the head of read return
mem_in_ready_to_receive  out  1  command accept enable
mem_in_data  out  LEN_DATA  head read-return word
mem_in_data_ready  out  1  return buffer non-empty
err_wr_no_data  out  1  sticky: write accepted without in_burst_done

Behaviour:
- Reset (rst==0 at a clk edge):
  - mem_in_ready_to_receive, mem_in_data_ready, err_wr_no_data = 0; mem_in_data = 0.
  - Latency pipe, return buffer, outstanding counter and refresh counter cleared; FSM goes to ST_RUN.
  - Array contents are not cleared.
  - Reset mid-traffic discards all in-flight reads.
- Word index = in_addr[ADDR_SHIFT +: log2(MEM_DEPTH)]; upper bits are ignored, so the address space aliases modulo MEM_DEPTH.
- Accept condition: accept = in_available & mem_in_ready_to_receive. At most one command per cycle.
- Write accept:
  - Each byte b with in_wdf_mask[b]==0 is updated at the accepting edge.
  - If in_burst_done==0, the write is still performed and err_wr_no_data sets; it stays set until reset.
- Read accept:
  - The array is read at the accepting edge, so a write accepted in an earlier cycle is visible (read-after-write ordering).
  - The word enters a READ_LATENCY-stage pipe, then the return FIFO.
  - mem_in_data_ready first rises READ_LATENCY cycles after the accept edge.
  - Returns are in accept order.
- Return FIFO:
  - mem_in_data is the FIFO head, registered.
  - Pop when mem_in_data_ready & in_receive_enbl.
  - in_receive_enbl while empty is ignored.
- Outstanding counter (width log2(RET_DEPTH)+1):
  - +1 on read accept, -1 on pop; simultaneous accept and pop leave it unchanged.
  - Never exceeds RET_DEPTH, so the FIFO cannot overflow and needs no full flag.
- mem_in_ready_to_receive = (state==ST_RUN) & (outstanding < RET_DEPTH) & rst. It is computed from registered state only, with no combinational path from inputs.
- Writes are throttled only by ready.
- FSM:
  - ST_RUN: the refresh counter increments each cycle. When it reaches REFRESH_PERIOD-1 it resets to 0 and the FSM moves to ST_REFRESH.
  - ST_REFRESH: ready = 0 for exactly REFRESH_LEN cycles, then back to ST_RUN.
  - Pipe and FIFO keep draining during refresh.
  - REFRESH_PERIOD==0: the FSM stays in ST_RUN.
- A command presented while ready==0 is not accepted. The initiator must hold it; the responder keeps no record of it.

Test Plan:
- Reset, then write addr 0x08 with data 0xA5 repeated and mask 0; read addr 0x08 -> data_ready rises exactly 4 cycles after read accept with data 0xA5 repeated; pop clears data_ready.
- Write 0xFF repeated to addr 0x10, then write 0x00 repeated with mask = all ones except bit 0 -> a read returns byte0 = 0x00 and all other bytes = 0xFF.
- 16 back-to-back reads of addrs 0,8,...,120 with receive_enbl held 0 -> ready drops after the 16th accept. Pop one -> ready rises the next cycle. All 16 return in issue order.
- Set REFRESH_PERIOD=32, REFRESH_LEN=8, in_available constantly high for reads with continuous pops -> ready low for cycles 32-39 and 72-79 (period counted from reset release); no command lost or duplicated.
- Write with in_burst_done=0 -> err_wr_no_data=1 and stays 1; array still updated; reset clears the flag.
- Reset asserted with 3 reads in flight -> data_ready = 0 and ready = 0 during reset; after release the first new read returns correctly with no stale data.
